nibble_serial_adder: RTL and testbench

Multi-precision adder that sits directly downstream of `four_rca`. It consumes the 4-bit sum and carry from one `four_rca` instance, one nibble per clock, and chains the carry through a register. The result is a full (4·NIBBLES)-bit sum with a final carry. Operands enter through a valid/ready handshake, and the result is held on a valid/ready output until it is taken.

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_four_rca.sv | 21 ++
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and types for the nibble-serial multi-precision adder.
package nibble_serial_adder_pkg;

   localparam int NIB_W = 4;

   // 2'd3 is unused; the FSM steers it back to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Nibble counter width: clog2(nibbles), never narrower than one bit.
   function automatic int cnt_width(input int nibbles);
      return (nibbles <= 1) ? 1 : $clog2(nibbles);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_four_rca.sv
// four_rca: 4-bit ripple-carry adder built from four full-adder cells.
module four_rca (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       carry_in,
   output logic [3:0] sum,
   output logic       carry
);

   logic [4:0] c;

   assign c[0] = carry_in;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign carry = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands one nibble per clock through a
// single four_rca, chaining the carry through c_reg. Operands arrive on a
// valid/ready handshake; the result is held on valid/ready until taken.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high (outside reset)
//   ADD   | one nibble summed per edge, cnt tracks the nibble index
//   DONE  | sum/carry valid and held until out_ready
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*NIBBLES-1:0] a,
   input  logic [NIB_W*NIBBLES-1:0] b,
   input  logic                     carry_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*NIBBLES-1:0] sum,
   output logic                     carry,
   output logic                     busy
);

   localparam int W     = NIB_W * NIBBLES;
   localparam int CNT_W = cnt_width(NIBBLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic [W-1:0]     a_sh;
   logic [W-1:0]     b_sh;
   logic [W-1:0]     sum_sh;
   logic             c_reg;
   logic [CNT_W-1:0] cnt;

   logic [NIB_W-1:0]   rca_sum;
   logic               rca_carry;
   logic [W+NIB_W-1:0] sum_cat;
   logic [W-1:0]       sum_sh_nxt;

   four_rca u_rca (
      .a        (a_sh[NIB_W-1:0]),
      .b        (b_sh[NIB_W-1:0]),
      .carry_in (c_reg),
      .sum      (rca_sum),
      .carry    (rca_carry)
   );

   // New nibble enters at the top while the accumulated sum shifts right;
   // the concatenation keeps this valid even when W equals one nibble.
   assign sum_cat    = {rca_sum, sum_sh};
   assign sum_sh_nxt = sum_cat[W+NIB_W-1:NIB_W];

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state == ADD);
   assign sum       = sum_sh;
   assign carry     = c_reg;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; only IDLE can take new operands.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept    = 1'b1;
               state_nxt = ADD;
            end
         end
         ADD: begin
            if (cnt == LAST_CNT) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand/result shift registers, carry chain and nibble counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         c_reg  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         c_reg <= carry_in;
         cnt   <= '0;
      end else if (state == ADD) begin
         a_sh   <= a_sh >> NIB_W;
         b_sh   <= b_sh >> NIB_W;
         sum_sh <= sum_sh_nxt;
         c_reg  <= rca_carry;
         cnt    <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: scoreboard queue filled at accept time,
// drained by a monitor on every output handshake. A second NIBBLES=1 instance
// covers the single-nibble build.
module tb_nibble_serial_adder;
   import nibble_serial_adder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        carry_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] sum;
   logic        carry;
   logic        busy;

   logic        in_valid1 = 1'b0;
   logic        in_ready1;
   logic [3:0]  a1 = '0;
   logic [3:0]  b1 = '0;
   logic        carry_in1 = 1'b0;
   logic        out_valid1;
   logic        out_ready1 = 1'b0;
   logic [3:0]  sum1;
   logic        carry1;
   logic        busy1;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_adder #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .carry(carry), .busy(busy)
   );

   nibble_serial_adder #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .carry_in(carry_in1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .carry(carry1), .busy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive operands until accepted; returns #1 after the accept edge.
   task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input bit keep_valid, output int acc_cyc);
      int k;
      logic [16:0] ref_sum;
      a = ta;
      b = tb_v;
      carry_in = tc;
      in_valid = 1'b1;
      k = 0;
      while (k < 50) begin
         @(negedge clk);
         if (in_ready) break;
         k++;
      end
      if (k == 50) begin
         check("accept_timeout", 32'd0, 32'd1);
      end
      ref_sum = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tc};
      exp_q.push_back(ref_sum);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 30) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every output handshake retires one scoreboard entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {15'd0, carry, sum}, 32'h1FFFF);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("result", {15'd0, carry, sum}, {15'd0, e});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, prev;
      logic [15:0] ra, rb;
      logic        rc;

      // Reset state
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Basic add, latency
      out_ready = 1'b1;
      send(16'h1234, 16'h4321, 1'b0, 1'b0, t0);
      check("basic_busy_e0", 32'(busy), 32'd1);
      for (int i = 1; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("basic_busy", 32'(busy), 32'd1);
         check("basic_no_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      check("basic_valid_e4", 32'(out_valid), 32'd1);
      check("basic_sum", 32'(sum), 32'h5555);
      wait_drain();

      // Full carry ripple, busy exactly 4 cycles
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0, t0);
      t1 = 1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (busy) t1++;
      end
      check("ripple_busy_cycles", 32'(t1), 32'd4);
      wait_drain();

      // Backpressure
      out_ready = 1'b0;
      send(16'h8000, 16'h8000, 1'b0, 1'b0, t0);
      repeat (4) @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         a = 16'h1111 * 16'(i + 1);
         b = 16'h0101;
         carry_in = 1'b1;
         in_valid = (i % 2 == 0);
         @(posedge clk);
         #1;
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_sum", 32'(sum), 32'h0000);
         check("bp_hold_carry", 32'(carry), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_retired", 32'(out_valid), 32'd0);
      check("bp_queue", 32'(exp_q.size()), 32'd0);

      // Back-to-back with a fixed first set, then random operands
      prev = -1;
      for (int i = 0; i < 201; i++) begin
         if (i == 0) begin
            ra = 16'hFFFF; rb = 16'h0001; rc = 1'b0;
         end else begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
         end
         send(ra, rb, rc, 1'b1, t0);
         if (prev >= 0) check("b2b_period", 32'(t0 - prev), 32'd6);
         prev = t0;
      end
      in_valid = 1'b0;
      wait_drain();

      // Reset in the middle of ADD
      send(16'h1111, 16'h2222, 1'b0, 1'b0, t0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_release_ready", 32'(in_ready), 32'd1);
      t1 = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid) t1++;
      end
      check("midrst_no_result", 32'(t1), 32'd0);
      send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, t0);
      wait_drain();

      // NIBBLES = 1 instance
      a1 = 4'd9; b1 = 4'd8; carry_in1 = 1'b1; in_valid1 = 1'b1;
      t1 = 0;
      while (t1 < 20) begin
         @(negedge clk);
         if (in_ready1) break;
         t1++;
      end
      check("n1_ready", 32'(in_ready1), 32'd1);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      check("n1_busy_e0", 32'(busy1), 32'd1);
      check("n1_no_valid_e0", 32'(out_valid1), 32'd0);
      @(posedge clk);
      #1;
      check("n1_valid_e1", 32'(out_valid1), 32'd1);
      check("n1_sum", 32'(sum1), 32'd2);
      check("n1_carry", 32'(carry1), 32'd1);
      out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      check("n1_retired", 32'(out_valid1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
